// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
//   Bundles the producer-side write port, the status flags and the uart_send
//   handshake of uart_tx_fifo into one interface.
//   slave  : used by uart_tx_fifo (consumes writes, drives status and TX_*).
//   master : used by whatever drives writes and models uart_send.
//   Signals:
//     WR_DATA[7:0], WR_EN, OVF_CLR      producer -> fifo
//     FULL, EMPTY, COUNT, OVERFLOW      fifo -> producer (status)
//     TX_DATA[7:0], TX_DATA_READY       fifo -> uart_send
//     TX_IDLE                           uart_send -> fifo
`timescale 1ns/1ps
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          WR_DATA;
    logic                WR_EN;
    logic                FULL;
    logic                EMPTY;
    logic [DEPTH_LOG2:0] COUNT;
    logic                OVERFLOW;
    logic                OVF_CLR;
    logic [7:0]          TX_DATA;
    logic                TX_DATA_READY;
    logic                TX_IDLE;

    modport slave (
        input  WR_DATA, WR_EN, OVF_CLR, TX_IDLE,
        output FULL, EMPTY, COUNT, OVERFLOW, TX_DATA, TX_DATA_READY
    );

    modport master (
        output WR_DATA, WR_EN, OVF_CLR, TX_IDLE,
        input  FULL, EMPTY, COUNT, OVERFLOW, TX_DATA, TX_DATA_READY
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO in front of uart_send. Producers may write one byte per cycle;
//   bytes are handed to uart_send one at a time with a single-cycle
//   TX_DATA_READY pulse, issued only while uart_send reports TX_IDLE.
//   If uart_send never drops TX_IDLE after a pulse, the byte is treated as
//   sent after ACK_TIMEOUT cycles so the queue cannot stall.
//   Ports:
//     CLK   system clock, rising edge
//     RST   asynchronous active-low reset
//     bus   uart_tx_fifo_if.slave (write port, status, uart_send handshake)
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int DEPTH_LOG2  = 4,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    uart_tx_fifo_if.slave     bus
);

    localparam int                  DEPTH     = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam int                  TMR_W     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0]    TMR_LAST  = TMR_W'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  full_reg;
    logic                  empty_reg;
    logic                  ovf_reg;
    logic [7:0]            tx_data_reg;
    logic                  ready_reg;
    state_t                state_reg;
    state_t                state_next;
    logic [TMR_W-1:0]      tmr_reg;
    logic [TMR_W-1:0]      tmr_next;
    logic                  push;
    logic                  pop;

    // Full is judged on the registered flag, so a write in the same cycle as
    // a pop from a full FIFO is still rejected.
    assign push = bus.WR_EN && !full_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Handshake sequencer: pop decision, timeout counter and next state.
    always_comb begin
        state_next = state_reg;
        tmr_next   = tmr_reg;
        pop        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!empty_reg && bus.TX_IDLE) begin
                    pop        = 1'b1;
                    tmr_next   = '0;
                    state_next = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (!bus.TX_IDLE) begin
                    tmr_next   = '0;
                    state_next = S_WAIT_DONE;
                end else if (tmr_reg == TMR_LAST) begin
                    // uart_send never acknowledged; count the byte as sent.
                    tmr_next   = '0;
                    state_next = S_IDLE;
                end else begin
                    tmr_next = tmr_reg + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (bus.TX_IDLE) begin
                    tmr_next   = '0;
                    state_next = S_IDLE;
                end
            end
            default: begin
                tmr_next   = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    // Storage array has no reset so it maps onto block RAM; contents are
    // simply ignored after reset because the pointers return to zero.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_reg] <= bus.WR_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            full_reg    <= 1'b0;
            empty_reg   <= 1'b1;
            ovf_reg     <= 1'b0;
            tx_data_reg <= 8'h00;
            ready_reg   <= 1'b0;
            state_reg   <= S_IDLE;
            tmr_reg     <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                tx_data_reg <= mem[rd_ptr_reg];
            end
            count_reg <= count_next;
            full_reg  <= (count_next == DEPTH_CNT);
            empty_reg <= (count_next == '0);
            // A rejected write sets the flag even if a clear arrives with it.
            if (bus.WR_EN && full_reg) begin
                ovf_reg <= 1'b1;
            end else if (bus.OVF_CLR) begin
                ovf_reg <= 1'b0;
            end
            // Pulse lasts one cycle: the FSM has left S_IDLE by the next edge.
            ready_reg <= pop;
            state_reg <= state_next;
            tmr_reg   <= tmr_next;
        end
    end

    assign bus.FULL          = full_reg;
    assign bus.EMPTY         = empty_reg;
    assign bus.COUNT         = count_reg;
    assign bus.OVERFLOW      = ovf_reg;
    assign bus.TX_DATA       = tx_data_reg;
    assign bus.TX_DATA_READY = ready_reg;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer and handshake sequencer between byte producers (the receive/echo path, future frame formatter) and the uart_send transmitter.
- Accepts single-cycle write strobes at any rate, stores up to 2^DEPTH_LOG2 bytes, and feeds uart_send one byte at a time.
- Issues a one-cycle DATA_READY pulse only when the transmitter reports IDLE.
- Lets producers burst without losing bytes while the serial line is busy.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries)
ACK_TIMEOUT, 4, max cycles to wait for TX_IDLE to fall after a DATA_READY pulse before treating the byte as sent

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  reset, asynchronous, active-low (RST=0 resets)
WR_DATA  input  8  byte to enqueue
WR_EN  input  1  enqueue strobe, sampled each cycle
FULL  output  1  FIFO holds 2^DEPTH_LOG2 bytes
EMPTY  output  1  FIFO holds 0 bytes
COUNT  output  DEPTH_LOG2+1  bytes currently stored
OVERFLOW  output  1  sticky: a write was attempted while FULL
OVF_CLR  input  1  synchronous clear of OVERFLOW
TX_DATA  output  8  byte to uart_send DATA
TX_DATA_READY  output  1  one-cycle send request to uart_send DATA_READY
TX_IDLE  input  1  uart_send IDLE

Behaviour:
- Reset (RST=0, asynchronous): pointers=0, COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0, TX_DATA=8'h00, TX_DATA_READY=0, timeout counter=0, state=S_IDLE. Stored contents are discarded. Reset mid-transfer aborts the FSM; uart_send finishes its current byte on its own.
- FULL, EMPTY and COUNT are registered and reflect state after the last edge.
- Write: WR_EN=1 and FULL=0 stores WR_DATA at wr_ptr; wr_ptr increments, wrapping modulo 2^DEPTH_LOG2.
- Write when full: WR_EN=1 and FULL=1 drops the byte; OVERFLOW <= 1 on the next edge. FULL is judged on the registered value, so the write is rejected even if a pop occurs in the same cycle.
- OVERFLOW: stays 1 until OVF_CLR=1. If OVF_CLR and an overflowing write occur in the same cycle, set wins.
- Simultaneous push and pop: COUNT is unchanged; both pointers advance.
- FSM states:
  - S_IDLE: if COUNT!=0 and TX_IDLE=1, then TX_DATA <= mem[rd_ptr], rd_ptr++, pop, TX_DATA_READY <= 1, go to S_WAIT_BUSY. Otherwise stay.
  - S_WAIT_BUSY: TX_DATA_READY <= 0, timeout counter increments.
    - TX_IDLE=0 -> S_WAIT_DONE.
    - Counter reaches ACK_TIMEOUT with TX_IDLE still 1 -> S_IDLE; the byte is considered sent and is not resent.
  - S_WAIT_DONE: TX_IDLE=1 -> S_IDLE, counter cleared.
- TX_DATA_READY is high for exactly one cycle per dequeued byte and never high in two consecutive cycles.
- TX_DATA holds its value from the load until the next load.
- Latency: WR_EN at edge N into an empty FIFO with TX_IDLE=1 gives COUNT=1 after edge N+1 and TX_DATA valid with TX_DATA_READY=1 after edge N+2.
- Minimum spacing between TX_DATA_READY pulses is 3 cycles.
- Bytes leave in write order; none are duplicated.

Test Plan:
- Reset/idle: hold RST=0, then release with no writes -> EMPTY=1, COUNT=0, TX_DATA_READY never asserts over 100 cycles.
- Single byte: write 8'h41 with the uart_send model idle -> exactly one TX_DATA_READY pulse 2 cycles later with TX_DATA=8'h41; COUNT returns to 0.
- Burst ordering: write 8'h01..8'h10 on 16 consecutive cycles while TX_IDLE=0 -> FULL=1 and COUNT=16. Release TX_IDLE with a model taking 10 bit-times per byte -> bytes 8'h01..8'h10 emitted in order, one pulse each.
- Overflow: with FIFO full, write 8'hFF -> OVERFLOW=1, COUNT stays 16, 8'hFF is never transmitted. Pulse OVF_CLR -> OVERFLOW=0.
- Wrap and concurrent push/pop: stream 40 bytes at one per 5 cycles while the sender drains -> pointers wrap at least twice, output sequence equals input sequence, OVERFLOW=0.
- Timeout and reset: hold TX_IDLE=1 permanently with 3 bytes queued -> one pulse per byte, with consecutive pulses ACK_TIMEOUT+2 cycles apart. Assert RST=0 mid-queue -> COUNT=0 and TX_DATA_READY=0 immediately, no pulses after release.
